// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and defaults for the PC redirect unit and the ID stage.
package pc_redirect_unit_pkg;

  localparam int PC_WIDTH_DEF  = 10;
  localparam int PC_STEP_DEF   = 1;
  localparam int RESET_PC_DEF  = 0;
  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_OP  = 2'd1,
    REDIRECT = 2'd2
  } redirect_state_e;

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Branch-resolution bus between the ID stage and the IF-side redirect unit.
interface pc_redirect_unit_if #(
  parameter int PC_WIDTH = 10
);

  logic                id_is_branch;
  logic                id_branch_ne;
  logic                id_cmp_eq;
  logic                id_operand_pending;
  logic [PC_WIDTH-1:0] id_target;
  logic [PC_WIDTH-1:0] pc_out;
  logic                if_flush;
  logic                id_hold;

  // ID-stage side: supplies the branch decision, consumes fetch control
  modport master (
    output id_is_branch, id_branch_ne, id_cmp_eq, id_operand_pending, id_target,
    input  pc_out, if_flush, id_hold
  );

  // Redirect unit side
  modport slave (
    input  id_is_branch, id_branch_ne, id_cmp_eq, id_operand_pending, id_target,
    output pc_out, if_flush, id_hold
  );

endinterface

// File: rtl/pc_redirect_unit_sat_counter.sv
// Saturating up-counter used for the debug statistics.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// PC register and branch redirect control for the IF stage.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal sequential fetch, branches resolve here
// WAIT_OP  | branch in ID waiting on a load result; fetch held
// REDIRECT | taken branch just redirected; ID holds the flushed bubble
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter int PC_STEP   = PC_STEP_DEF,
  parameter int RESET_PC  = RESET_PC_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_en,
  pc_redirect_unit_if.slave    bus,
  output logic [CNT_WIDTH-1:0] taken_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  redirect_state_e     state_q, state_nxt;
  logic [PC_WIDTH-1:0] pc_q, pc_nxt, pc_seq;
  logic                taken;
  logic                flush_c;
  logic                hold_c;

  assign taken  = bus.id_cmp_eq ^ bus.id_branch_ne;
  assign pc_seq = pc_q + PC_WIDTH'(PC_STEP);

  // Next PC/state and the Mealy flush/hold decisions.
  // RUN and WAIT_OP share one rule set: a branch that stops pending
  // resolves in the same cycle, one that vanishes falls back to fetch.
  always_comb begin
    pc_nxt    = pc_q;
    state_nxt = state_q;
    flush_c   = 1'b0;
    hold_c    = 1'b0;
    if (fetch_en) begin
      case (state_q)
        RUN, WAIT_OP: begin
          if (bus.id_is_branch && bus.id_operand_pending) begin
            hold_c    = 1'b1;
            state_nxt = WAIT_OP;
          end else if (bus.id_is_branch && taken) begin
            flush_c   = 1'b1;
            pc_nxt    = bus.id_target;
            state_nxt = REDIRECT;
          end else begin
            pc_nxt    = pc_seq;
            state_nxt = RUN;
          end
        end
        REDIRECT: begin
          pc_nxt    = pc_seq;
          state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // PC and state registers; reset drops any pending redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= PC_WIDTH'(RESET_PC);
      state_q <= RUN;
    end else begin
      pc_q    <= pc_nxt;
      state_q <= state_nxt;
    end
  end

  // Mealy outputs are forced quiet while reset is asserted so IF/ID is
  // never frozen or flushed by a stale branch during reset.
  assign bus.pc_out   = pc_q;
  assign bus.if_flush = flush_c & rst_n;
  assign bus.id_hold  = hold_c & rst_n;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_c),
    .count (taken_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hold_c),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios, then random
// branch traffic compared against a behavioural fetch model.
module tb_pc_redirect_unit;

  localparam int PW = 10;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  logic fetch_en;
  logic [CW-1:0] taken_cnt;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  int pc_m;
  int taken_m;
  int stall_m;
  bit bubble_m;
  bit exp_flush;
  bit exp_hold;

  pc_redirect_unit_if #(.PC_WIDTH(PW)) bus ();

  pc_redirect_unit #(
    .PC_WIDTH  (PW),
    .PC_STEP   (1),
    .RESET_PC  (0),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_en  (fetch_en),
    .bus       (bus),
    .taken_cnt (taken_cnt),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pc_m = 0; taken_m = 0; stall_m = 0; bubble_m = 1'b0;
  endtask

  // One fetch cycle: called just after a rising edge. Drives inputs,
  // checks the Mealy outputs, advances the model, then checks registers.
  task automatic do_cycle(input bit fe, input bit br, input bit ne, input bit eq,
                          input bit pend, input logic [PW-1:0] tgt);
    fetch_en = fe;
    bus.id_is_branch = br;
    bus.id_branch_ne = ne;
    bus.id_cmp_eq = eq;
    bus.id_operand_pending = pend;
    bus.id_target = tgt;
    #1;
    exp_flush = 1'b0;
    exp_hold = 1'b0;
    if (fe) begin
      if (bubble_m) begin
        pc_m = (pc_m + 1) % (1 << PW);
        bubble_m = 1'b0;
      end else if (br && pend) begin
        exp_hold = 1'b1;
        stall_m = (stall_m < CMAX) ? stall_m + 1 : CMAX;
      end else if (br && (eq != ne)) begin
        exp_flush = 1'b1;
        pc_m = int'(tgt);
        taken_m = (taken_m < CMAX) ? taken_m + 1 : CMAX;
        bubble_m = 1'b1;
      end else begin
        pc_m = (pc_m + 1) % (1 << PW);
      end
    end
    check("if_flush", 32'(bus.if_flush), 32'(exp_flush));
    check("id_hold", 32'(bus.id_hold), 32'(exp_hold));
    @(posedge clk);
    #1;
    check("pc_out", 32'(bus.pc_out), 32'(pc_m));
    check("taken_cnt", 32'(taken_cnt), 32'(taken_m));
    check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_en = 1'b0;
    bus.id_is_branch = 1'b0;
    bus.id_branch_ne = 1'b0;
    bus.id_cmp_eq = 1'b0;
    bus.id_operand_pending = 1'b0;
    bus.id_target = '0;
    model_reset();

    #12;
    check("rst_pc", 32'(bus.pc_out), 32'd0);
    check("rst_taken", 32'(taken_cnt), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_flush", 32'(bus.if_flush), 32'd0);
    check("rst_hold", 32'(bus.id_hold), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("pc_after_release", 32'(bus.pc_out), 32'd0);

    // sequential fetch 0 -> 3
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 0, 0, 0, '0);
    check("pc_is_3", 32'(bus.pc_out), 32'd3);

    // BEQ taken at pc=3 to 0x40, bubble (branch ignored) to 0x41
    do_cycle(1, 1, 0, 1, 0, 10'h040);
    check("pc_is_40", 32'(bus.pc_out), 32'h40);
    do_cycle(1, 1, 0, 1, 0, 10'h200);
    check("pc_is_41", 32'(bus.pc_out), 32'h41);

    // BNE with equal operands: not taken
    do_cycle(1, 1, 1, 1, 0, 10'h155);

    // BEQ waits two cycles on a load, then redirects to 0x10
    do_cycle(1, 1, 0, 1, 1, 10'h010);
    do_cycle(1, 1, 0, 1, 1, 10'h010);
    check("stall_is_2", 32'(stall_cnt), 32'd2);
    do_cycle(1, 1, 0, 1, 0, 10'h010);
    check("pc_is_10", 32'(bus.pc_out), 32'h10);
    do_cycle(1, 0, 0, 0, 0, '0);

    // wrap from 0x3FF to 0x000
    do_cycle(1, 1, 1, 0, 0, 10'h3FE);
    do_cycle(1, 0, 0, 0, 0, '0);
    check("pc_is_3ff", 32'(bus.pc_out), 32'h3FF);
    do_cycle(1, 0, 0, 0, 0, '0);
    check("pc_wrap", 32'(bus.pc_out), 32'h000);

    // fetch_en low over a resolvable taken branch, then release
    do_cycle(0, 1, 0, 1, 0, 10'h0AA);
    do_cycle(0, 1, 0, 1, 0, 10'h0AA);
    do_cycle(1, 1, 0, 1, 0, 10'h0AA);
    do_cycle(0, 0, 0, 0, 0, '0);
    do_cycle(1, 0, 0, 0, 0, '0);

    // branch to self
    do_cycle(1, 1, 0, 1, 0, 10'h0AB);
    do_cycle(1, 0, 0, 0, 0, '0);

    // waiting branch disappears: no redirect
    do_cycle(1, 1, 0, 1, 1, 10'h300);
    do_cycle(1, 0, 0, 1, 0, 10'h300);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      do_cycle(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0), PW'($urandom));
    end

    // enter WAIT_OP, then reset asynchronously mid-cycle
    do_cycle(1, 0, 0, 0, 0, '0);
    do_cycle(1, 1, 0, 1, 1, 10'h123);
    #1;
    check("hold_before_rst", 32'(bus.id_hold), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", 32'(bus.pc_out), 32'd0);
    check("async_rst_hold", 32'(bus.id_hold), 32'd0);
    check("async_rst_taken", 32'(taken_cnt), 32'd0);
    check("async_rst_stall", 32'(stall_cnt), 32'd0);
    fetch_en = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 0, 0, 0, '0);
    check("pc_after_rst", 32'(bus.pc_out), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
